// File: rtl/sm4_key_sched.sv
// SM4 key expansion: serial 32-round schedule, one round key per cycle.
// Optional round-key readback register file enabled by SM4_KEY_READBACK_EN.

module transform_for_key_exp (
    input  logic [31:0] x_word,
    output logic [31:0] t_word
);
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [31:0] b_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign b_word[gi*8 +: 8] = SBOX[x_word[gi*8 +: 8]];
        end
    endgenerate

    // Key-schedule linear layer: B ^ (B <<< 13) ^ (B <<< 23)
    assign t_word = b_word ^ {b_word[18:0], b_word[31:19]} ^ {b_word[8:0], b_word[31:9]};
endmodule

module sm4_key_sched (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         key_done,
    output logic         key_ready,
    input  logic [4:0]   rd_addr,
    output logic [31:0]  rd_data
);
    localparam logic [127:0] FK      = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [31:0]  CK_SEED = 32'h00070E15;

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state_reg;
    logic [31:0] k0_reg, k1_reg, k2_reg, k3_reg;
    logic [31:0] ck_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] ck_next;
    logic [31:0] x_word;
    logic [31:0] t_word;
    logic [31:0] new_word;
    logic [127:0] k_init;
    logic        start_ok;

    // CK bytes advance by 28 each round with no carry between bytes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ck
            assign ck_next[gi*8 +: 8] = ck_reg[gi*8 +: 8] + 8'h1C;
        end
    endgenerate

    assign x_word   = k1_reg ^ k2_reg ^ k3_reg ^ ck_reg;
    assign new_word = k0_reg ^ t_word;
    assign k_init   = key_in ^ FK;
    // A start coinciding with the final beat (busy falling) is not accepted
    assign start_ok = key_start && (state_reg == IDLE) && !key_done;

    transform_for_key_exp u_transform (
        .x_word (x_word),
        .t_word (t_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            k0_reg    <= '0;
            k1_reg    <= '0;
            k2_reg    <= '0;
            k3_reg    <= '0;
            ck_reg    <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_out    <= '0;
            rk_idx    <= '0;
            key_done  <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            key_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        k0_reg    <= k_init[127:96];
                        k1_reg    <= k_init[95:64];
                        k2_reg    <= k_init[63:32];
                        k3_reg    <= k_init[31:0];
                        ck_reg    <= CK_SEED;
                        cnt_reg   <= '0;
                        state_reg <= EXPAND;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    k0_reg   <= k1_reg;
                    k1_reg   <= k2_reg;
                    k2_reg   <= k3_reg;
                    k3_reg   <= new_word;
                    ck_reg   <= ck_next;
                    rk_out   <= new_word;
                    rk_idx   <= cnt_reg;
                    rk_valid <= 1'b1;
                    if (cnt_reg == 5'd31) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        key_done  <= 1'b1;
                        key_ready <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SM4_KEY_READBACK_EN
    logic [31:0] store_reg [32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                store_reg[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (state_reg == EXPAND) begin
                store_reg[cnt_reg] <= new_word;
            end
            rd_data <= store_reg[rd_addr];
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif
endmodule

// File: doc/sm4_key_sched.md
SM4_KEY_SCHED -- requirements
Module: sm4_key_sched

Interface
REQ-001 SHALL have no parameters; round count fixed at 32.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 key_start  input  1  one-cycle request to expand key_in.
REQ-005 key_in  input  128  master key MK0..MK3, MK0 = key_in[127:96].
REQ-006 busy  output  1  high while expansion in progress.
REQ-007 rk_valid  output  1  rk_out/rk_idx valid this cycle.
REQ-008 rk_out  output  32  current round key rk[i].
REQ-009 rk_idx  output  5  index i of rk_out.
REQ-010 key_done  output  1  one-cycle pulse with the rk[31] beat.
REQ-011 key_ready  output  1  level; all 32 round keys stored and valid.
REQ-012 rd_addr  input  5  round-key readback address.
REQ-013 rd_data  output  32  registered readback data.

Function
REQ-014 SHALL be the upstream driver of transform_for_key_exp (T' = 4 S-boxes, then L'(B) = B ^ B<<<13 ^ B<<<23), instantiating it once.
REQ-015 States SHALL be IDLE, EXPAND; key_start accepted only in IDLE, ignored while busy.
REQ-016 On accepted start: K0..K3 <= MKi ^ FKi (FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC), round counter <= 0, CK seed <= 0x00070E15, state <= EXPAND, busy <= 1, key_ready <= 0.
REQ-017 Each EXPAND cycle: X = K1^K2^K3^CK; new = K0 ^ T'(X); K0..K3 <= K1,K2,K3,new; rk_out <= new; rk_idx <= counter; rk_valid <= 1.
REQ-018 CK byte j of round i SHALL be (28i+7j) mod 256; generated by adding 0x1C1C1C1C bytewise (each byte mod 256, no carry between bytes) per round, no ROM.
REQ-019 rk_valid SHALL be high exactly 32 consecutive cycles, starting 2 cycles after the start edge, with rk_idx 0..31 in order.
REQ-020 When counter = 31: state <= IDLE, busy <= 0 next cycle; key_done pulses and key_ready rises together with the rk_idx=31 beat.
REQ-021 key_start in the same cycle busy falls is ignored; the first accepted restart is the next IDLE cycle.
REQ-022 key_ready SHALL stay high until the next accepted key_start or reset.
REQ-023 Counter wrap from 31 SHALL never occur; counter holds in IDLE.
REQ-024 rk_out/rk_idx SHALL hold last values when rk_valid is low.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, busy=0, rk_valid=0, rk_out=0, rk_idx=0, key_done=0, key_ready=0, rd_data=0, K0..K3=0, counter=0.
REQ-026 Reset mid-expansion SHALL abort; no further rk_valid beats; restart requires new key_start.
REQ-027 With readback compiled in, all 32 storage words SHALL reset to 0.

Configuration
REQ-028 Macro SM4_KEY_READBACK_EN: defined -> 32x32 register file written at rk_idx on every rk_valid; rd_data <= store[rd_addr], 1-cycle latency; unwritten/overwriting entries return current contents.
REQ-029 SM4_KEY_READBACK_EN undefined -> no storage, rd_addr ignored, rd_data constant 0; all other behaviour unchanged.

Verification
REQ-030 key_in=0123456789ABCDEFFEDCBA9876543210, pulse start -> rk_idx0=F12186F9 at cycle 2, rk_idx31=9124A012 at cycle 33 with key_done=1, key_ready=1.
REQ-031 Same key, 31 round keys checked against software model; CK at round 1 observed as 1C232A31, round 31 as 646B7279.
REQ-032 key_start re-pulsed at cycles 5 and 33 of an expansion -> ignored; exactly 32 beats; start at cycle 34 accepted, key_ready drops at cycle 35.
REQ-033 reset_n low at cycle 10 -> all outputs 0 within same cycle, no beats after release until new start.
REQ-034 SM4_KEY_READBACK_EN defined, after REQ-030 expansion, rd_addr=31 -> rd_data=9124A012 next cycle; rd_addr=0 -> F12186F9; undefined -> rd_data=0.
